// File: rtl/quad_decoder.sv
// 4x quadrature decoder: synchronises and filters A/B/Z, then tracks position,
// direction, A-rise period (omega), stall and illegal double-bit transitions.
module quad_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3,
    parameter int POS_W       = 16,
    parameter int PER_W       = 8,
    parameter int STALL_LIMIT = 255,
    parameter int INDEX_EN    = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             A,
    input  logic             B,
    input  logic             Z,
    input  logic             clr_pos,
    input  logic             err_clr,
    output logic             is_cw,
    output logic             is_ccw,
    output logic [POS_W-1:0] position,
    output logic [PER_W-1:0] omega,
    output logic             omega_valid,
    output logic             stalled,
    output logic             err
);

    localparam int SETTLE = SYNC_STAGES + FILT_LEN;
    localparam int FCW    = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam int ICW    = $clog2(SETTLE + 1);

    localparam logic [FCW-1:0]   FILT_LAST   = FCW'(FILT_LEN - 1);
    localparam logic [ICW-1:0]   SETTLE_LAST = ICW'(SETTLE - 1);
    localparam logic [PER_W-1:0] STALL_CNT   = PER_W'(STALL_LIMIT);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t state;
    state_t state_next;

    logic [SYNC_STAGES-1:0][2:0] sync_q;
    logic [2:0]                  synced;
    logic [2:0]                  filt;
    logic [FCW-1:0]              fcnt [3];

    logic [ICW-1:0]   init_cnt;
    logic             settled;
    logic             init_done;
    logic             load_base;

    logic [1:0]       base_ab;
    logic [1:0]       cur_ab;
    logic             z_prev;
    logic             z_rise;
    logic             step_cw;
    logic             step_ccw;
    logic             illegal;
    logic             a_rise;
    logic             pos_clear;
    logic             stall_hit;
    logic             armed;
    logic [PER_W-1:0] per_cnt;

    function automatic logic [1:0] cw_next(input logic [1:0] ab);
        case (ab)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    // Bit order in every 3-bit bundle is {A, B, Z}.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], {A, B, Z}};
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            filt <= '0;
            for (int i = 0; i < 3; i++) begin
                fcnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (synced[i] != filt[i]) begin
                    if (fcnt[i] == FILT_LAST) begin
                        filt[i] <= synced[i];
                        fcnt[i] <= '0;
                    end else begin
                        fcnt[i] <= fcnt[i] + 1'b1;
                    end
                end else begin
                    fcnt[i] <= '0;
                end
            end
        end
    end

    // Baseline is taken only once the sync/filter pipeline has flushed its
    // post-reset zeros, so a non-zero resting position never looks like a step.
    assign settled   = (synced[2:1] == filt[2:1]);
    assign init_done = settled && (init_cnt == SETTLE_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            init_cnt <= '0;
        end else if (state == ST_INIT) begin
            if (!settled) begin
                init_cnt <= '0;
            end else if (init_cnt != SETTLE_LAST) begin
                init_cnt <= init_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_INIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_base  = 1'b0;
        case (state)
            ST_INIT: begin
                if (init_done) begin
                    state_next = ST_RUN;
                    load_base  = 1'b1;
                end
            end
            ST_RUN: begin
                state_next = ST_RUN;
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

    assign cur_ab = filt[2:1];
    assign z_rise = filt[0] & ~z_prev;

    always_comb begin
        step_cw  = 1'b0;
        step_ccw = 1'b0;
        illegal  = 1'b0;
        a_rise   = 1'b0;
        if (state == ST_RUN) begin
            step_cw  = (cw_next(base_ab) == cur_ab);
            step_ccw = (cw_next(cur_ab) == base_ab);
            illegal  = ((cur_ab ^ base_ab) == 2'b11);
            a_rise   = cur_ab[1] & ~base_ab[1];
        end
    end

    assign pos_clear = clr_pos | ((INDEX_EN != 0) & z_rise);
    assign stall_hit = (per_cnt == STALL_CNT) && !stalled && !a_rise;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            base_ab <= '0;
            z_prev  <= 1'b0;
        end else begin
            z_prev <= filt[0];
            if (load_base || (state == ST_RUN)) begin
                base_ab <= cur_ab;
            end
        end
    end

    // A clear swallows a coincident step, but the direction flags still follow it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            position <= '0;
            is_cw    <= 1'b0;
            is_ccw   <= 1'b0;
            err      <= 1'b0;
        end else begin
            if (pos_clear) begin
                position <= '0;
            end else if (step_cw) begin
                position <= position + 1'b1;
            end else if (step_ccw) begin
                position <= position - 1'b1;
            end

            if (step_cw) begin
                is_cw  <= 1'b1;
                is_ccw <= 1'b0;
            end else if (step_ccw) begin
                is_cw  <= 1'b0;
                is_ccw <= 1'b1;
            end else if (stall_hit) begin
                is_cw  <= 1'b0;
                is_ccw <= 1'b0;
            end

            if (illegal) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

    // 'armed' marks that a reference A rise exists, so the next rise yields a real period.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            per_cnt     <= '0;
            omega       <= '0;
            omega_valid <= 1'b0;
            stalled     <= 1'b0;
            armed       <= 1'b0;
        end else begin
            omega_valid <= 1'b0;
            if (a_rise) begin
                per_cnt <= PER_W'(1);
                stalled <= 1'b0;
                armed   <= 1'b1;
                if (armed) begin
                    omega       <= per_cnt;
                    omega_valid <= 1'b1;
                end
            end else begin
                if (per_cnt < STALL_CNT) begin
                    per_cnt <= per_cnt + 1'b1;
                end
                if (stall_hit) begin
                    stalled <= 1'b1;
                    omega   <= '0;
                    armed   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder: a scoreboard queue holds expected position and
// flags per encoder edge, popped after the fixed pipeline latency.
module tb_quad_decoder;

    localparam int LAT = 2 + 3 + 1;
    localparam int GAP = 8;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic        a       = 1'b0;
    logic        b       = 1'b0;
    logic        z       = 1'b0;
    logic        clr_pos = 1'b0;
    logic        err_clr = 1'b0;

    logic        is_cw, is_ccw, omega_valid, stalled, err;
    logic [15:0] position;
    logic [7:0]  omega;

    logic        is_cw4, is_ccw4, omega_valid4, stalled4, err4;
    logic [3:0]  position4;
    logic [7:0]  omega4;

    quad_decoder dut (
        .clock(clock), .reset_n(reset_n), .A(a), .B(b), .Z(z),
        .clr_pos(clr_pos), .err_clr(err_clr),
        .is_cw(is_cw), .is_ccw(is_ccw), .position(position), .omega(omega),
        .omega_valid(omega_valid), .stalled(stalled), .err(err)
    );

    quad_decoder #(.POS_W(4)) dut4 (
        .clock(clock), .reset_n(reset_n), .A(a), .B(b), .Z(z),
        .clr_pos(clr_pos), .err_clr(err_clr),
        .is_cw(is_cw4), .is_ccw(is_ccw4), .position(position4), .omega(omega4),
        .omega_valid(omega_valid4), .stalled(stalled4), .err(err4)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int errors   = 0;
    int ov_count = 0;
    int ov_base  = 0;

    always @(negedge clock) begin
        if (omega_valid) ov_count++;
    end

    typedef struct {
        string       tag;
        logic [15:0] pos;
        logic        cw;
        logic        ccw;
        logic        err;
    } exp_t;

    exp_t       sb_q[$];
    int         m_pos;
    logic       m_cw, m_ccw, m_err, m_z;
    logic [1:0] m_ab;

    function automatic logic [1:0] cw_of(input logic [1:0] ab);
        case (ab)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] ccw_of(input logic [1:0] ab);
        case (ab)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input logic [1:0] ab);
        reset_n = 1'b0;
        {a, b}  = ab;
        z       = 1'b0;
        clr_pos = 1'b0;
        err_clr = 1'b0;
        m_pos = 0; m_cw = 1'b0; m_ccw = 1'b0; m_err = 1'b0; m_z = 1'b0; m_ab = ab;
        sb_q.delete();
        tick(2);
        reset_n = 1'b1;
        tick(20);
    endtask

    // Drives one encoder state and pushes what the outputs must show LAT edges later.
    task automatic apply_stimulus(input logic [1:0] ab, input logic zv, input logic clr, input string tag);
        logic clear;
        clear = clr | (zv & ~m_z);
        if (cw_of(m_ab) == ab) begin
            m_pos++; m_cw = 1'b1; m_ccw = 1'b0;
        end else if (ccw_of(m_ab) == ab) begin
            m_pos--; m_cw = 1'b0; m_ccw = 1'b1;
        end else if (ab != m_ab) begin
            m_err = 1'b1;
        end
        if (clear) m_pos = 0;
        m_ab = ab;
        m_z  = zv;
        {a, b} = ab;
        z      = zv;
        sb_q.push_back('{tag, m_pos[15:0], m_cw, m_ccw, m_err});
    endtask

    task automatic check_output();
        exp_t e;
        check_val("sb_ready", 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() == 0) return;
        e = sb_q.pop_front();
        check_val({e.tag, "_pos"},  32'(position),  32'(e.pos));
        check_val({e.tag, "_pos4"}, 32'(position4), 32'(e.pos[3:0]));
        check_val({e.tag, "_cw"},   32'(is_cw),     32'(e.cw));
        check_val({e.tag, "_ccw"},  32'(is_ccw),    32'(e.ccw));
        check_val({e.tag, "_err"},  32'(err),       32'(e.err));
    endtask

    task automatic step(input logic [1:0] ab, input logic zv, input string tag);
        apply_stimulus(ab, zv, 1'b0, tag);
        tick(LAT);
        check_output();
        tick(GAP - LAT);
    endtask

    initial begin
        $display("[TB] reset with A=B=1, baseline load");
        do_reset(2'b11);
        check_val("rst_pos",     32'(position), 32'd0);
        check_val("rst_err",     32'(err),      32'd0);
        check_val("rst_dir",     32'({is_cw, is_ccw}), 32'd0);
        check_val("rst_omega",   32'(omega),    32'd0);
        check_val("rst_stalled", 32'(stalled),  32'd0);
        check_val("rst_ov",      32'(ov_count), 32'd0);
        apply_stimulus(2'b01, 1'b0, 1'b0, "base_step");
        tick(LAT - 1);
        check_val("lat_early_pos", 32'(position), 32'd0);
        tick(1);
        check_output();

        $display("[TB] clockwise run, 10 electrical cycles");
        do_reset(2'b00);
        ov_base = ov_count;
        for (int k = 0; k < 40; k++) step(cw_of(m_ab), 1'b0, "cw");
        check_val("cw_omega", 32'(omega), 32'd32);
        check_val("cw_ov",    32'(ov_count - ov_base), 32'd9);

        $display("[TB] reverse to counter-clockwise");
        for (int k = 0; k < 6; k++) step(ccw_of(m_ab), 1'b0, "ccw");
        check_val("ccw_omega", 32'(omega), 32'd32);
        check_val("ccw_ov",    32'(ov_count - ov_base), 32'd11);

        $display("[TB] glitch and illegal transitions");
        a = 1'b0;
        tick(2);
        a = 1'b1;
        tick(12);
        check_val("glitch_pos",   32'(position), 32'd34);
        check_val("glitch_err",   32'(err),      32'd0);
        check_val("glitch_omega", 32'(omega),    32'd32);
        apply_stimulus(2'b00, 1'b0, 1'b0, "ill_11_00");
        tick(LAT - 1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check_output();
        tick(1);
        check_val("err_sticky", 32'(err), 32'd1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        m_err = 1'b0;
        check_val("err_cleared", 32'(err), 32'd0);
        apply_stimulus(2'b11, 1'b0, 1'b0, "ill_00_11");
        tick(LAT);
        check_output();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        m_err = 1'b0;
        check_val("err_cleared2", 32'(err), 32'd0);

        $display("[TB] stall and resume");
        tick(300);
        check_val("stall_flag",  32'(stalled),  32'd1);
        check_val("stall_omega", 32'(omega),    32'd0);
        check_val("stall_dir",   32'({is_cw, is_ccw}), 32'd0);
        check_val("stall_pos",   32'(position), 32'd34);
        m_cw = 1'b0; m_ccw = 1'b0;
        ov_base = ov_count;
        for (int k = 0; k < 3; k++) step(cw_of(m_ab), 1'b0, "resume");
        check_val("resume_unstall", 32'(stalled), 32'd0);
        check_val("resume_no_ov",   32'(ov_count - ov_base), 32'd0);
        for (int k = 0; k < 4; k++) step(cw_of(m_ab), 1'b0, "resume2");
        check_val("resume_ov",    32'(ov_count - ov_base), 32'd1);
        check_val("resume_omega", 32'(omega), 32'd32);

        $display("[TB] mid-run reset, wrap and clears");
        #3;
        reset_n = 1'b0;
        #1;
        check_val("async_rst_pos",   32'(position), 32'd0);
        check_val("async_rst_omega", 32'(omega),    32'd0);
        check_val("async_rst_cw",    32'(is_cw),    32'd0);
        do_reset(2'b00);
        for (int k = 0; k < 9; k++) step(cw_of(m_ab), 1'b0, "wrap");
        check_val("wrap_pos4", 32'(position4), 32'(4'b1001));
        check_val("wrap_pos",  32'(position),  32'd9);
        step(cw_of(m_ab), 1'b1, "z_index");
        clr_pos = 1'b1;
        apply_stimulus(ccw_of(m_ab), 1'b1, 1'b1, "clr_step");
        tick(LAT);
        check_output();
        clr_pos = 1'b0;
        tick(GAP - LAT);
        step(cw_of(m_ab), 1'b1, "after_clr");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
